// File: rtl/ef_tcc32_evt_pkg.sv
// ef_tcc32_evt_pkg: edge_sel encodings and default parameters for the TCC32 event conditioner
package ef_tcc32_evt_pkg;
  typedef enum logic [1:0] {EDGE_NONE = 2'b00, EDGE_RISE = 2'b01, EDGE_FALL = 2'b10, EDGE_BOTH = 2'b11} edge_sel_e;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FLT_W = 8;
  localparam int DEF_PSC_W = 8;
endpackage

// File: rtl/ef_tcc32_evt_cond_if.sv
// ef_tcc32_evt_cond_if: event pin, enable and config (en, evt_in, flt_len, edge_sel, psc) in; evt_level, evt_pulse out
interface ef_tcc32_evt_cond_if
  import ef_tcc32_evt_pkg::*;
#(
  parameter int FLT_W = DEF_FLT_W,
  parameter int PSC_W = DEF_PSC_W
);
  logic en;
  logic evt_in;
  logic [FLT_W-1:0] flt_len;
  logic [1:0] edge_sel;
  logic [PSC_W-1:0] psc;
  logic evt_level;
  logic evt_pulse;
  modport master (output en, evt_in, flt_len, edge_sel, psc, input evt_level, evt_pulse);
  modport slave (input en, evt_in, flt_len, edge_sel, psc, output evt_level, evt_pulse);
endinterface

// File: rtl/ef_sync.sv
// ef_sync: STAGES-deep reset-to-0 synchronizer; ports clk, rst, d (async in), q (synchronized out)
module ef_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r;
  always_ff @(posedge clk) r <= rst ? '0 : {r[STAGES-2:0], d};
  assign q = r[STAGES-1];
endmodule

// File: rtl/ef_tcc32_evt_cond.sv
// ef_tcc32_evt_cond: sync + glitch filter + edge select + prescaler; ports clk, rst, bus (slave: en/evt_in/flt_len/edge_sel/psc in, evt_level/evt_pulse out)
module ef_tcc32_evt_cond
  import ef_tcc32_evt_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FLT_W = DEF_FLT_W,
  parameter int PSC_W = DEF_PSC_W
) (
  input logic clk,
  input logic rst,
  ef_tcc32_evt_cond_if.slave bus
);
  logic s, lvl, pulse, acc, qual;
  logic [FLT_W-1:0] fcnt;
  logic [PSC_W-1:0] pcnt;
  ef_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d(bus.evt_in), .q(s));
  assign acc = bus.en && (s != lvl) && (fcnt >= bus.flt_len);
  assign qual = acc && (s ? bus.edge_sel[0] : bus.edge_sel[1]);
  always_ff @(posedge clk) begin
    if (rst) begin
      lvl <= 1'b0;
      fcnt <= '0;
      pcnt <= '0;
      pulse <= 1'b0;
    end else if (!bus.en) begin
      lvl <= s;
      fcnt <= '0;
      pcnt <= '0;
      pulse <= 1'b0;
    end else begin
      lvl <= acc ? s : lvl;
      fcnt <= (s == lvl || acc) ? '0 : fcnt + 1'b1;
      pulse <= qual && (pcnt >= bus.psc);
      pcnt <= !qual ? pcnt : (pcnt >= bus.psc) ? '0 : pcnt + 1'b1;
    end
  end
  assign bus.evt_level = lvl;
  assign bus.evt_pulse = pulse;
endmodule
